// File: rtl/enose_snn_core.sv
// enose_snn_core: two-layer LIF SNN over one buffered AXI-Stream spike window; tready only in RECV.
// One weight per cycle: N_HIDDEN*(N_IN+2)+N_OUT*(N_HIDDEN+2)+1 cycles/timestep; ENOSE_CONF_EN adds the conf port.
module enose_snn_core #(
  parameter int N_IN      = 12,
  parameter int N_HIDDEN  = 32,
  parameter int N_OUT     = 3,
  parameter int W_LEN_MAX = 64,
  parameter int WW        = 8,
  parameter int VW        = 16,
  parameter int CW        = 16,
  localparam int LW       = $clog2(W_LEN_MAX + 1),
  localparam int OCW      = $clog2(N_OUT)
) (
  input  logic                 s00_axi_aclk,
  input  logic                 s00_axi_aresetn,
  input  logic                 start,
  input  logic                 soft_reset,
  input  logic [LW-1:0]        window_len,
  input  logic signed [VW-1:0] th_h,
  input  logic signed [VW-1:0] th_o,
  input  logic [3:0]           leak_h,
  input  logic [3:0]           leak_o,
  input  logic                 wr_en,
  input  logic                 wr_layer,
  input  logic [15:0]          wr_addr,
  input  logic [WW-1:0]        wr_data,
  input  logic [31:0]          s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [OCW-1:0]       result_class,
  output logic [N_OUT*CW-1:0]  counts,
  output logic [LW-1:0]        recv_len,
  output logic [31:0]          latency,
  output logic [31:0]          h_spike_total
`ifdef ENOSE_CONF_EN
  ,
  output logic [CW-1:0]        conf
`endif
);

  localparam int TW  = $clog2(W_LEN_MAX);
  localparam int NW  = $clog2(N_HIDDEN);
  localparam int PW  = $clog2(N_IN + N_HIDDEN + 2);
  localparam int A1N = N_IN * N_HIDDEN;
  localparam int A2N = N_HIDDEN * N_OUT;
  localparam int A1W = $clog2(A1N);
  localparam int A2W = $clog2(A2N);
  localparam logic [PW-1:0] H_LAST = PW'(N_IN + 1);
  localparam logic [PW-1:0] O_LAST = PW'(N_HIDDEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_HID, S_OUT, S_NEXT, S_DONE} state_t;

  state_t state, state_n;

  logic [N_IN-1:0]        sbuf [W_LEN_MAX];
  logic signed [WW-1:0]   w1 [A1N];
  logic signed [WW-1:0]   w2 [A2N];
  logic signed [WW-1:0]   w1_q, w2_q;
  logic signed [VW-1:0]   vh [N_HIDDEN];
  logic signed [VW-1:0]   vo [N_OUT];
  logic [CW-1:0]          cnt [N_OUT];
  logic signed [VW-1:0]   acc, th_h_r, th_o_r;
  logic [3:0]             leak_h_r, leak_o_r;
  logic [N_HIDDEN-1:0]    hspk;
  logic [LW-1:0]          wlen, beats, t;
  logic [PW-1:0]          ph;
  logic [NW-1:0]          nidx;
  logic                   gate, gate_q;
  logic [31:0]            lat, htot;
  logic [A1W-1:0]         ra1;
  logic [A2W-1:0]         ra2;

  logic accept, last_beat, len_ok, start_go, start_bad, wr_ok, wr_drop;
  logic unused_tdata;

  function automatic logic signed [VW-1:0] sat(input logic [VW:0] x);
    if (x[VW] != x[VW-1])
      return x[VW] ? {1'b1, {(VW-1){1'b0}}} : {1'b0, {(VW-1){1'b1}}};
    return x[VW-1:0];
  endfunction

  assign unused_tdata  = ^s_axis_tdata[31:N_IN];
  assign busy          = (state != S_IDLE);
  assign s_axis_tready = (state == S_RECV);
  assign accept        = (state == S_RECV) && s_axis_tvalid;
  assign last_beat     = accept && (s_axis_tlast || (beats + LW'(1) == wlen));
  assign len_ok        = (window_len != '0) && (window_len <= LW'(W_LEN_MAX));
  assign start_go      = (state == S_IDLE) && start && !soft_reset && len_ok;
  assign start_bad     = (state == S_IDLE) && start && !soft_reset && !len_ok;
  assign wr_ok         = wr_en && (state == S_IDLE) &&
                         (wr_layer ? (wr_addr < 16'(A2N)) : (wr_addr < 16'(A1N)));
  assign wr_drop       = wr_en && !wr_ok;

  // Address issue and spike gating for the current phase; gate travels with the 1-cycle RAM read.
  always_comb begin
    ra1  = '0;
    ra2  = '0;
    gate = 1'b0;
    for (int i = 0; i < N_IN; i++)
      if (state == S_HID && ph == PW'(i)) begin
        ra1  = A1W'(i * N_HIDDEN) + A1W'(nidx);
        gate = sbuf[t[TW-1:0]][i];
      end
    for (int j = 0; j < N_HIDDEN; j++)
      if (state == S_OUT && ph == PW'(j)) begin
        ra2  = A2W'(j * N_OUT) + A2W'(nidx);
        gate = hspk[j];
      end
  end

  logic signed [VW-1:0] vcur, vshift, vleak, vnew, th_sel, acc_nxt;
  logic signed [WW-1:0] wq;
  logic [3:0]           lk;
  logic                 fire;

  always_comb begin
    vcur    = (state == S_OUT) ? vo[nidx[OCW-1:0]] : vh[nidx];
    lk      = (state == S_OUT) ? leak_o_r : leak_h_r;
    th_sel  = (state == S_OUT) ? th_o_r : th_h_r;
    wq      = (state == S_OUT) ? w2_q : w1_q;
    vshift  = vcur >>> lk;
    vleak   = sat({vcur[VW-1], vcur} - {vshift[VW-1], vshift});
    vnew    = sat({vleak[VW-1], vleak} + {acc[VW-1], acc});
    fire    = (vnew >= th_sel);
    acc_nxt = sat({acc[VW-1], acc} + {{(VW-WW+1){wq[WW-1]}}, wq});
  end

  logic [OCW-1:0] best;
  logic [CW-1:0]  best_v;
`ifdef ENOSE_CONF_EN
  logic [CW-1:0]  second_v;
`endif

  always_comb begin
    best   = '0;
    best_v = cnt[0];
    for (int k = 1; k < N_OUT; k++)
      if (cnt[k] > best_v) begin
        best   = OCW'(k);
        best_v = cnt[k];
      end
`ifdef ENOSE_CONF_EN
    second_v = '0;
    for (int k = 0; k < N_OUT; k++)
      if (OCW'(k) != best && cnt[k] > second_v) second_v = cnt[k];
`endif
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start_go) state_n = S_RECV;
      S_RECV: if (last_beat) state_n = S_HID;
      S_HID:  if (ph == H_LAST && nidx == NW'(N_HIDDEN - 1)) state_n = S_OUT;
      S_OUT:  if (ph == O_LAST && nidx == NW'(N_OUT - 1)) state_n = S_NEXT;
      S_NEXT: state_n = (t + LW'(1) == beats) ? S_DONE : S_HID;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (soft_reset) state_n = S_IDLE;
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) state <= S_IDLE;
    else                  state <= state_n;
  end

  // Weight and spike storage: contents survive reset.
  always_ff @(posedge s00_axi_aclk) begin
    if (wr_ok && !wr_layer) w1[wr_addr[A1W-1:0]] <= wr_data;
    if (wr_ok && wr_layer)  w2[wr_addr[A2W-1:0]] <= wr_data;
    if (accept) sbuf[beats[TW-1:0]] <= s_axis_tdata[N_IN-1:0];
    w1_q <= w1[ra1];
    w2_q <= w2[ra2];
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      err <= 1'b0; done <= 1'b0; result_class <= '0; counts <= '0;
      recv_len <= '0; latency <= '0; h_spike_total <= '0;
`ifdef ENOSE_CONF_EN
      conf <= '0;
`endif
      wlen <= '0; beats <= '0; t <= '0; ph <= '0; nidx <= '0; acc <= '0;
      gate_q <= 1'b0; hspk <= '0; lat <= '0; htot <= '0;
      th_h_r <= '0; th_o_r <= '0; leak_h_r <= '0; leak_o_r <= '0;
      for (int i = 0; i < N_HIDDEN; i++) vh[i] <= '0;
      for (int k = 0; k < N_OUT; k++) begin vo[k] <= '0; cnt[k] <= '0; end
    end else begin
      err    <= wr_drop | start_bad;
      done   <= 1'b0;
      gate_q <= gate;
      if (soft_reset || start_go) begin
        beats <= '0; t <= '0; ph <= '0; nidx <= '0; acc <= '0;
        hspk <= '0; lat <= '0; htot <= '0;
        for (int i = 0; i < N_HIDDEN; i++) vh[i] <= '0;
        for (int k = 0; k < N_OUT; k++) begin vo[k] <= '0; cnt[k] <= '0; end
        if (start_go) begin
          wlen <= window_len; th_h_r <= th_h; th_o_r <= th_o;
          leak_h_r <= leak_h; leak_o_r <= leak_o;
        end
      end else begin
        case (state)
          S_RECV: begin
            if (accept) beats <= beats + LW'(1);
            if (accept || beats != '0) lat <= lat + 32'd1;
          end
          S_HID, S_OUT: begin
            lat <= lat + 32'd1;
            if (ph == ((state == S_HID) ? H_LAST : O_LAST)) begin
              ph  <= '0;
              acc <= '0;
              if (state == S_HID) begin
                vh[nidx] <= fire ? '0 : vnew;
                if (fire) begin
                  hspk[nidx] <= 1'b1;
                  htot       <= htot + 32'd1;
                end
                nidx <= (nidx == NW'(N_HIDDEN - 1)) ? '0 : nidx + NW'(1);
              end else begin
                vo[nidx[OCW-1:0]] <= fire ? '0 : vnew;
                if (fire && cnt[nidx[OCW-1:0]] != {CW{1'b1}})
                  cnt[nidx[OCW-1:0]] <= cnt[nidx[OCW-1:0]] + CW'(1);
                nidx <= (nidx == NW'(N_OUT - 1)) ? '0 : nidx + NW'(1);
              end
            end else begin
              ph <= ph + PW'(1);
              if (gate_q) acc <= acc_nxt;
            end
          end
          S_NEXT: begin
            lat  <= lat + 32'd1;
            hspk <= '0;
            t    <= t + LW'(1);
          end
          S_DONE: begin
            for (int k = 0; k < N_OUT; k++) counts[k*CW +: CW] <= cnt[k];
            result_class  <= best;
            recv_len      <= beats;
            latency       <= lat + 32'd1;
            h_spike_total <= htot;
            done          <= 1'b1;
`ifdef ENOSE_CONF_EN
            conf <= best_v - second_v;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule
